// File: rtl/controlador_varredura_colunas_pkg.sv
// pkg_matriz
// Shared definitions for the 5x7 LED dot-matrix column-scan path.
//   - estado_t         : scan controller state encoding
//   - N_COLUNAS_PADRAO : default number of matrix columns
//   - LARGURA_PADRAO   : default rows per column
//   - fatia_coluna()   : extracts one column pattern from a default-geometry frame
package pkg_matriz;

  typedef enum logic [1:0] {
    PARADO  = 2'd0,
    APAGADO = 2'd1,
    CARGA   = 2'd2,
    EXIBE   = 2'd3
  } estado_t;

  localparam int N_COLUNAS_PADRAO = 5;
  localparam int LARGURA_PADRAO   = 7;

  // Column c occupies bits [LARGURA*c +: LARGURA] of the frame; column 0 is the LSBs.
  function automatic logic [LARGURA_PADRAO-1:0] fatia_coluna(
    input logic [N_COLUNAS_PADRAO*LARGURA_PADRAO-1:0] quadro,
    input int unsigned                                c
  );
    return LARGURA_PADRAO'(quadro >> (LARGURA_PADRAO * c));
  endfunction

endpackage

// File: rtl/controlador_varredura_colunas_contador.sv
// contador_modulo
// Terminal-count up counter used for the blank and dwell timers.
// While 'conta' is high it counts 0..TERMINAL-1 and wraps; while low it is held at 0,
// so each visit to a timed state starts from a fresh count.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   conta : count enable; low clears the counter
//   fim   : high while the count sits on its terminal value (TERMINAL-1)
module contador_modulo #(
  parameter  int TERMINAL = 4,
  localparam int W        = (TERMINAL > 1) ? $clog2(TERMINAL) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic conta,
  output logic fim
);

  localparam logic [W-1:0] ULTIMO = W'(TERMINAL - 1);

  logic [W-1:0] valor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valor <= '0;
    end else if (!conta) begin
      valor <= '0;
    end else if (valor == ULTIMO) begin
      valor <= '0;
    end else begin
      valor <= valor + 1'b1;
    end
  end

  assign fim = (valor == ULTIMO);

endmodule

// File: rtl/controlador_varredura_colunas.sv
// controlador_varredura_colunas
// Column-scan controller for the 5x7 LED dot-matrix. For every column it blanks the
// matrix, pulses 'sinal' so the downstream row register loads the column pattern from
// 'bits', then enables that column for a fixed dwell. New frames are buffered and only
// become active at a frame boundary (or when scanning starts), so the image never tears.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   habilita     : scanning enabled while high
//   atualiza     : one-cycle strobe, capture 'padrao' as the next frame
//   padrao       : frame, column c = padrao[LARGURA*c +: LARGURA]
//   bits         : column pattern for the row register parallel inputs
//   sinal        : one-cycle load strobe for the row register
//   d            : row register serial input, tied to 0
//   colunas      : one-hot active-high column enable, all zero while blank
//   coluna_atual : index of the column being served
//   fim_quadro   : one-cycle pulse in the first blank cycle after the last column
module controlador_varredura_colunas
  import pkg_matriz::*;
#(
  parameter  int N_COLUNAS      = N_COLUNAS_PADRAO,
  parameter  int LARGURA        = LARGURA_PADRAO,
  parameter  int CICLOS_COLUNA  = 1000,
  parameter  int CICLOS_APAGADO = 2,
  localparam int LC             = (N_COLUNAS > 1) ? $clog2(N_COLUNAS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         habilita,
  input  logic                         atualiza,
  input  logic [N_COLUNAS*LARGURA-1:0] padrao,
  output logic [LARGURA-1:0]           bits,
  output logic                         sinal,
  output logic                         d,
  output logic [N_COLUNAS-1:0]         colunas,
  output logic [LC-1:0]                coluna_atual,
  output logic                         fim_quadro
);

  localparam logic [LC-1:0]        ULTIMA = LC'(N_COLUNAS - 1);
  localparam logic [N_COLUNAS-1:0] UM     = N_COLUNAS'(1);

  estado_t                      estado;
  logic [N_COLUNAS*LARGURA-1:0] quadro;
  logic [N_COLUNAS*LARGURA-1:0] quadro_pendente;
  logic                         pendente;
  logic                         fim_apagado;
  logic                         fim_exibe;
  logic                         fronteira;
  logic [LARGURA-1:0]           fatia_atual;

  contador_modulo #(.TERMINAL(CICLOS_APAGADO)) u_tempo_apagado (
    .clk   (clk),
    .rst   (rst),
    .conta (estado == APAGADO),
    .fim   (fim_apagado)
  );

  contador_modulo #(.TERMINAL(CICLOS_COLUNA)) u_tempo_exibe (
    .clk   (clk),
    .rst   (rst),
    .conta (estado == EXIBE),
    .fim   (fim_exibe)
  );

  assign d = 1'b0;

  assign fatia_atual = LARGURA'(quadro >> (LARGURA * int'(coluna_atual)));

  // The active frame may only change when scanning starts or when the last column's
  // dwell ends, i.e. just before column 0 is loaded again.
  assign fronteira = habilita &&
                     ((estado == PARADO) ||
                      ((estado == EXIBE) && fim_exibe && (coluna_atual == ULTIMA)));

  // A strobe on the boundary cycle bypasses the pending buffer; otherwise the last
  // strobe seen since the previous boundary wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quadro          <= '0;
      quadro_pendente <= '0;
      pendente        <= 1'b0;
    end else if (fronteira) begin
      if (atualiza) begin
        quadro <= padrao;
      end else if (pendente) begin
        quadro <= quadro_pendente;
      end
      pendente <= 1'b0;
    end else if (atualiza) begin
      quadro_pendente <= padrao;
      pendente        <= 1'b1;
    end
  end

  // Scan FSM with registered outputs: each output takes the value belonging to the
  // state being entered, so sinal and colunas can never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado       <= PARADO;
      bits         <= '0;
      sinal        <= 1'b0;
      colunas      <= '0;
      coluna_atual <= '0;
      fim_quadro   <= 1'b0;
    end else begin
      sinal      <= 1'b0;
      fim_quadro <= 1'b0;
      if (!habilita) begin
        estado       <= PARADO;
        bits         <= '0;
        colunas      <= '0;
        coluna_atual <= '0;
      end else begin
        case (estado)
          PARADO: begin
            estado       <= APAGADO;
            coluna_atual <= '0;
          end
          APAGADO: begin
            if (fim_apagado) begin
              estado <= CARGA;
              sinal  <= 1'b1;
              bits   <= fatia_atual;
            end
          end
          CARGA: begin
            estado  <= EXIBE;
            colunas <= UM << coluna_atual;
          end
          EXIBE: begin
            if (fim_exibe) begin
              estado  <= APAGADO;
              colunas <= '0;
              if (coluna_atual == ULTIMA) begin
                coluna_atual <= '0;
                fim_quadro   <= 1'b1;
              end else begin
                coluna_atual <= coluna_atual + 1'b1;
              end
            end
          end
          default: begin
            estado  <= PARADO;
            colunas <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_controlador_varredura_colunas.sv
// tb_controlador_varredura_colunas
// Directed bench for the column-scan controller with 5 columns, 7 rows, a 4-cycle
// dwell and a 1-cycle blank (6-cycle column slot, 30-cycle frame).
module tb_controlador_varredura_colunas;

  localparam int N_COLUNAS      = 5;
  localparam int LARGURA        = 7;
  localparam int CICLOS_COLUNA  = 4;
  localparam int CICLOS_APAGADO = 1;

  // Column 0 is the rightmost 7-bit field of each frame.
  localparam logic [34:0] P1 = 35'h1_2345_6789;  // 09 4F 15 1A 12
  localparam logic [34:0] P2 = {7'h55, 7'h2A, 7'h7F, 7'h00, 7'h33};
  localparam logic [34:0] P3 = {7'h01, 7'h02, 7'h03, 7'h04, 7'h05};
  localparam logic [34:0] P4 = {7'h11, 7'h22, 7'h44, 7'h08, 7'h70};
  localparam logic [34:0] P5 = {7'h7E, 7'h3C, 7'h18, 7'h66, 7'h0F};
  localparam logic [34:0] P6 = {7'h6D, 7'h4B, 7'h27, 7'h1E, 7'h5A};

  logic        clk = 1'b0;
  logic        rst;
  logic        habilita;
  logic        atualiza;
  logic [34:0] padrao;
  logic [6:0]  bits;
  logic        sinal;
  logic        d;
  logic [4:0]  colunas;
  logic [2:0]  coluna_atual;
  logic        fim_quadro;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  controlador_varredura_colunas #(
    .N_COLUNAS      (N_COLUNAS),
    .LARGURA        (LARGURA),
    .CICLOS_COLUNA  (CICLOS_COLUNA),
    .CICLOS_APAGADO (CICLOS_APAGADO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .habilita     (habilita),
    .atualiza     (atualiza),
    .padrao       (padrao),
    .bits         (bits),
    .sinal        (sinal),
    .d            (d),
    .colunas      (colunas),
    .coluna_atual (coluna_atual),
    .fim_quadro   (fim_quadro)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic h, input logic a, input logic [34:0] p);
    habilita = h;
    atualiza = a;
    padrao   = p;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered in the blank cycle of column c; leaves in the blank cycle of the next column.
  // Any atualiza strobe set up by the caller is dropped after the first edge.
  task automatic scan_column(input int c, input logic [6:0] exp_bits, input logic exp_fim);
    logic [4:0] oh;
    oh = 5'b00001 << c;
    check_output($sformatf("blank_colunas_c%0d", c), 64'(colunas), 64'd0);
    check_output($sformatf("blank_sinal_c%0d", c), 64'(sinal), 64'd0);
    check_output($sformatf("blank_coluna_atual_c%0d", c), 64'(coluna_atual), 64'(c));
    check_output($sformatf("blank_fim_quadro_c%0d", c), 64'(fim_quadro), 64'(exp_fim));
    step();
    atualiza = 1'b0;
    check_output($sformatf("load_sinal_c%0d", c), 64'(sinal), 64'd1);
    check_output($sformatf("load_bits_c%0d", c), 64'(bits), 64'(exp_bits));
    check_output($sformatf("load_colunas_c%0d", c), 64'(colunas), 64'd0);
    check_output($sformatf("load_fim_quadro_c%0d", c), 64'(fim_quadro), 64'd0);
    for (int k = 0; k < CICLOS_COLUNA; k++) begin
      step();
      check_output($sformatf("dwell_colunas_c%0d_k%0d", c, k), 64'(colunas), 64'(oh));
      check_output($sformatf("dwell_sinal_c%0d_k%0d", c, k), 64'(sinal), 64'd0);
      check_output($sformatf("dwell_bits_c%0d_k%0d", c, k), 64'(bits), 64'(exp_bits));
    end
    step();
  endtask

  // Invariants sampled mid-cycle throughout the run.
  always @(negedge clk) begin
    checks += 3;
    assert (!(sinal && (|colunas))) else begin
      errors++;
      $error("[TB] FAIL inv_sinal_colunas observed sinal=%0b colunas=%b expected no overlap", sinal, colunas);
    end
    assert ($onehot0(colunas)) else begin
      errors++;
      $error("[TB] FAIL inv_onehot0 observed %b expected at most one bit", colunas);
    end
    assert (d === 1'b0) else begin
      errors++;
      $error("[TB] FAIL inv_d observed %b expected 0", d);
    end
  end

  initial begin
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, '0);
    #12;
    check_output("rst_bits", 64'(bits), 64'd0);
    check_output("rst_sinal", 64'(sinal), 64'd0);
    check_output("rst_colunas", 64'(colunas), 64'd0);
    check_output("rst_coluna_atual", 64'(coluna_atual), 64'd0);
    check_output("rst_fim_quadro", 64'(fim_quadro), 64'd0);
    rst = 1'b0;
    step();
    check_output("idle_colunas", 64'(colunas), 64'd0);
    check_output("idle_sinal", 64'(sinal), 64'd0);

    // Capture P1 while stopped, then start; P1 becomes active on leaving PARADO.
    apply_stimulus(1'b0, 1'b1, P1);
    step();
    apply_stimulus(1'b1, 1'b0, P1);
    step();

    // Frame 1: P1.
    scan_column(0, 7'h09, 1'b0);
    scan_column(1, 7'h4F, 1'b0);
    scan_column(2, 7'h15, 1'b0);
    scan_column(3, 7'h1A, 1'b0);
    scan_column(4, 7'h12, 1'b0);

    // Frame 2: P2 captured during column 2 must not show until the next frame.
    scan_column(0, 7'h09, 1'b1);
    scan_column(1, 7'h4F, 1'b0);
    apply_stimulus(1'b1, 1'b1, P2);
    scan_column(2, 7'h15, 1'b0);
    scan_column(3, 7'h1A, 1'b0);
    scan_column(4, 7'h12, 1'b0);

    // Frame 3: P2 shown; two strobes (P3 then P4) in this frame.
    scan_column(0, 7'h33, 1'b1);
    apply_stimulus(1'b1, 1'b1, P3);
    scan_column(1, 7'h00, 1'b0);
    scan_column(2, 7'h7F, 1'b0);
    apply_stimulus(1'b1, 1'b1, P4);
    scan_column(3, 7'h2A, 1'b0);
    scan_column(4, 7'h55, 1'b0);

    // Frame 4: only P4 appears; stop during the dwell of column 3.
    scan_column(0, 7'h70, 1'b1);
    scan_column(1, 7'h08, 1'b0);
    scan_column(2, 7'h44, 1'b0);
    check_output("c3_blank_coluna_atual", 64'(coluna_atual), 64'd3);
    step();
    check_output("c3_load_sinal", 64'(sinal), 64'd1);
    check_output("c3_load_bits", 64'(bits), 64'h22);
    step();
    check_output("c3_dwell_colunas", 64'(colunas), 64'b01000);
    apply_stimulus(1'b0, 1'b0, P4);
    step();
    check_output("stop_colunas", 64'(colunas), 64'd0);
    check_output("stop_coluna_atual", 64'(coluna_atual), 64'd0);
    check_output("stop_sinal", 64'(sinal), 64'd0);
    step();
    check_output("stopped_colunas", 64'(colunas), 64'd0);

    // Strobe P5 while stopped; it must be applied when scanning restarts.
    apply_stimulus(1'b0, 1'b1, P5);
    step();
    apply_stimulus(1'b0, 1'b0, P5);
    step();
    check_output("stopped2_sinal", 64'(sinal), 64'd0);
    check_output("stopped2_colunas", 64'(colunas), 64'd0);
    apply_stimulus(1'b1, 1'b0, P5);
    step();
    check_output("restart_blank_sinal", 64'(sinal), 64'd0);
    check_output("restart_blank_colunas", 64'(colunas), 64'd0);
    check_output("restart_coluna_atual", 64'(coluna_atual), 64'd0);
    step();
    check_output("restart_load_sinal", 64'(sinal), 64'd1);
    check_output("restart_load_bits", 64'(bits), 64'h0F);
    step();
    check_output("restart_dwell_colunas", 64'(colunas), 64'b00001);

    // Leave P6 pending, then reset asynchronously between edges.
    apply_stimulus(1'b1, 1'b1, P6);
    step();
    atualiza = 1'b0;
    step();
    #2;
    rst      = 1'b1;
    habilita = 1'b0;
    #1;
    check_output("async_rst_colunas", 64'(colunas), 64'd0);
    check_output("async_rst_sinal", 64'(sinal), 64'd0);
    check_output("async_rst_coluna_atual", 64'(coluna_atual), 64'd0);
    check_output("async_rst_bits", 64'(bits), 64'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_output($sformatf("post_rst_colunas_%0d", k), 64'(colunas), 64'd0);
      check_output($sformatf("post_rst_sinal_%0d", k), 64'(sinal), 64'd0);
    end

    // Reset cleared both the active frame and the pending P6: column 0 loads zero.
    apply_stimulus(1'b1, 1'b0, '0);
    step();
    check_output("post_rst_blank_sinal", 64'(sinal), 64'd0);
    step();
    check_output("post_rst_load_sinal", 64'(sinal), 64'd1);
    check_output("post_rst_load_bits", 64'(bits), 64'd0);
    check_output("post_rst_load_coluna_atual", 64'(coluna_atual), 64'd0);
    step();
    check_output("post_rst_dwell_colunas", 64'(colunas), 64'b00001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
